// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler
// Tile-level sequencer for the RowPar x ColPar output-stationary MAC array.
// A job of M x K x N is cut into ceil(M/RowPar) x ceil(N/ColPar) output
// tiles, walked with the N-tile index innermost. Each tile takes K+2 cycles:
// K fetch cycles, one drain cycle for the SRAM read latency, and one
// write-back cycle that stores the tile into SRAM C with edge masks.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  job start, only looked at while idle
//   M/K/N_size_i             job dimensions, captured when a start is taken
//   sram_a/b_addr_o          registered read addresses for the A and B SRAMs
//   sram_c_addr_o, _we_o     registered write address and strobe for SRAM C
//   mac_valid_o              array operand valid, aligned with SRAM read data
//   mac_init_save_o          first-k strobe, product replaces the accumulator
//   mac_acc_clr_o            accumulator clear while no job is in flight
//   row_valid_o/col_valid_o  per-row/per-column mask of the tile being written
//   busy_o, done_o           job in flight / one-cycle job completion pulse
module gemm_tile_scheduler #(
   parameter int InDataWidth   = 8,
   parameter int AddrWidth     = 16,
   parameter int SizeAddrWidth = 8,
   parameter int RowPar        = 4,
   parameter int ColPar        = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [SizeAddrWidth-1:0] M_size_i,
   input  logic [SizeAddrWidth-1:0] K_size_i,
   input  logic [SizeAddrWidth-1:0] N_size_i,
   output logic [AddrWidth-1:0]     sram_a_addr_o,
   output logic [AddrWidth-1:0]     sram_b_addr_o,
   output logic [AddrWidth-1:0]     sram_c_addr_o,
   output logic                     sram_c_we_o,
   output logic                     mac_valid_o,
   output logic                     mac_init_save_o,
   output logic                     mac_acc_clr_o,
   output logic [RowPar-1:0]        row_valid_o,
   output logic [ColPar-1:0]        col_valid_o,
   output logic                     busy_o,
   output logic                     done_o
);

   // The element width only documents the array being sequenced; this block
   // carries no element data, so the parameter has nothing to size here.
   if (InDataWidth < 1) begin : g_no_element_width
   end

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_e;

   state_e                   state_q, state_d;
   logic [SizeAddrWidth-1:0] m_size_q, m_size_d, k_size_q, k_size_d, n_size_q, n_size_d;
   logic [SizeAddrWidth-1:0] mt_tiles_q, mt_tiles_d, nt_tiles_q, nt_tiles_d;
   logic [SizeAddrWidth-1:0] mt_q, mt_d, nt_q, nt_d, k_q, k_d;
   logic [AddrWidth-1:0]     a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
   logic                     c_we_q, c_we_d, valid_q, valid_d, init_save_q, init_save_d;
   logic [RowPar-1:0]        row_valid_q, row_valid_d;
   logic [ColPar-1:0]        col_valid_q, col_valid_d;

   // Tile counts are rounded up one bit wider so a size of all-ones cannot
   // wrap while the rounding constant is added.
   logic [SizeAddrWidth:0]   m_round, n_round;
   assign m_round = {1'b0, M_size_i} + (SizeAddrWidth+1)'(RowPar - 1);
   assign n_round = {1'b0, N_size_i} + (SizeAddrWidth+1)'(ColPar - 1);

   // Next-state and next-output logic. Address and write-back registers are
   // loaded from the state being entered, so they are already valid in the
   // first cycle of FETCH/WRITE. The MAC strobes are the FETCH conditions of
   // the current cycle, which lands them one cycle later next to SRAM data.
   always_comb begin
      state_d     = state_q;
      m_size_d    = m_size_q;
      k_size_d    = k_size_q;
      n_size_d    = n_size_q;
      mt_tiles_d  = mt_tiles_q;
      nt_tiles_d  = nt_tiles_q;
      mt_d        = mt_q;
      nt_d        = nt_q;
      k_d         = k_q;
      a_addr_d    = a_addr_q;
      b_addr_d    = b_addr_q;
      c_addr_d    = c_addr_q;
      c_we_d      = 1'b0;
      row_valid_d = '0;
      col_valid_d = '0;
      valid_d     = (state_q == FETCH);
      init_save_d = (state_q == FETCH) && (k_q == '0);

      case (state_q)
         IDLE: begin
            if (start_i) begin
               m_size_d   = M_size_i;
               k_size_d   = K_size_i;
               n_size_d   = N_size_i;
               mt_tiles_d = SizeAddrWidth'(m_round / (SizeAddrWidth+1)'(RowPar));
               nt_tiles_d = SizeAddrWidth'(n_round / (SizeAddrWidth+1)'(ColPar));
               mt_d       = '0;
               nt_d       = '0;
               k_d        = '0;
               if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         FETCH: begin
            if (k_q == k_size_q - SizeAddrWidth'(1)) begin
               state_d = DRAIN;
            end else begin
               k_d = k_q + SizeAddrWidth'(1);
            end
         end
         DRAIN: state_d = WRITE;
         WRITE: begin
            k_d     = '0;
            state_d = FETCH;
            if (nt_q == nt_tiles_q - SizeAddrWidth'(1)) begin
               nt_d = '0;
               if (mt_q == mt_tiles_q - SizeAddrWidth'(1)) begin
                  state_d = DONE;
               end else begin
                  mt_d = mt_q + SizeAddrWidth'(1);
               end
            end else begin
               nt_d = nt_q + SizeAddrWidth'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A and B are tile-blocked: each M-tile (N-tile) owns K consecutive words.
      if (state_d == FETCH) begin
         a_addr_d = AddrWidth'(mt_d) * AddrWidth'(k_size_d) + AddrWidth'(k_d);
         b_addr_d = AddrWidth'(nt_d) * AddrWidth'(k_size_d) + AddrWidth'(k_d);
      end

      // Write-back address and edge masks use the tile that just drained.
      if (state_d == WRITE) begin
         c_we_d   = 1'b1;
         c_addr_d = AddrWidth'(mt_q) * AddrWidth'(nt_tiles_q) + AddrWidth'(nt_q);
         for (int r = 0; r < RowPar; r++) begin
            row_valid_d[r] = (int'(mt_q) * RowPar + r) < int'(m_size_q);
         end
         for (int c = 0; c < ColPar; c++) begin
            col_valid_d[c] = (int'(nt_q) * ColPar + c) < int'(n_size_q);
         end
      end
   end

   // State and output registers; reset drops any job in flight at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         m_size_q    <= '0;
         k_size_q    <= '0;
         n_size_q    <= '0;
         mt_tiles_q  <= '0;
         nt_tiles_q  <= '0;
         mt_q        <= '0;
         nt_q        <= '0;
         k_q         <= '0;
         a_addr_q    <= '0;
         b_addr_q    <= '0;
         c_addr_q    <= '0;
         c_we_q      <= 1'b0;
         valid_q     <= 1'b0;
         init_save_q <= 1'b0;
         row_valid_q <= '0;
         col_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         m_size_q    <= m_size_d;
         k_size_q    <= k_size_d;
         n_size_q    <= n_size_d;
         mt_tiles_q  <= mt_tiles_d;
         nt_tiles_q  <= nt_tiles_d;
         mt_q        <= mt_d;
         nt_q        <= nt_d;
         k_q         <= k_d;
         a_addr_q    <= a_addr_d;
         b_addr_q    <= b_addr_d;
         c_addr_q    <= c_addr_d;
         c_we_q      <= c_we_d;
         valid_q     <= valid_d;
         init_save_q <= init_save_d;
         row_valid_q <= row_valid_d;
         col_valid_q <= col_valid_d;
      end
   end

   assign sram_a_addr_o   = a_addr_q;
   assign sram_b_addr_o   = b_addr_q;
   assign sram_c_addr_o   = c_addr_q;
   assign sram_c_we_o     = c_we_q;
   assign mac_valid_o     = valid_q;
   assign mac_init_save_o = init_save_q;
   assign row_valid_o     = row_valid_q;
   assign col_valid_o     = col_valid_q;
   assign mac_acc_clr_o   = (state_q == IDLE) || (state_q == DONE);
   assign busy_o          = (state_q == FETCH) || (state_q == DRAIN) || (state_q == WRITE);
   assign done_o          = (state_q == DONE);

endmodule

// File: doc/gemm_tile_scheduler.md
# gemm_tile_scheduler

Tile-level sequencer for the RowPar x ColPar output-stationary MAC array of the GeMM accelerator. It splits an M x K x N job into ceil(M/RowPar) x ceil(N/ColPar) output tiles and, for each tile, issues K read addresses to SRAM A and SRAM B. It drives the array's valid, init-save and clear controls, then writes the finished tile to SRAM C with row/column edge masks. It sits between the top-level start/size inputs and the MAC array plus SRAM ports, and replaces flat K-counting.

## Interface
- InDataWidth, 8: element width; informational only, no datapath in this block.
- AddrWidth, 16: SRAM address width.
- SizeAddrWidth, 8: width of the size inputs, internal counters and tile counts.
- RowPar, 4: array rows; A word holds RowPar elements.
- ColPar, 16: array columns; B word holds ColPar elements.
- clk_i  in  1  clock, single domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  job start; sampled only in IDLE.
- M_size_i, K_size_i, N_size_i  in  SizeAddrWidth each  job dimensions; captured at accepted start.
- sram_a_addr_o, sram_b_addr_o  out  AddrWidth  read addresses, registered.
- sram_c_addr_o  out  AddrWidth  write address, registered.
- sram_c_we_o  out  1  tile write-back strobe.
- mac_valid_o  out  1  drives the array's a_valid/b_valid.
- mac_init_save_o  out  1  first-k strobe: the array loads the product instead of accumulating.
- mac_acc_clr_o  out  1  array accumulator clear.
- row_valid_o  out  RowPar  per-row mask of the tile being written.
- col_valid_o  out  ColPar  per-column mask of the tile being written.
- busy_o, done_o  out  1 each.

## Operation
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE -> FETCH on start_i. M/K/N are latched. MT=ceil(M/RowPar) and NT=ceil(N/ColPar) are computed. Tile counters mt, nt and k are set to 0.
- IDLE -> DONE instead if any latched size is 0. No reads and no writes occur.
- start_i outside IDLE is ignored.
- FETCH: one cycle per k, k=0..K-1.
  - sram_a_addr_o = mt*K + k (A is tile-blocked: per M-tile, K column words).
  - sram_b_addr_o = nt*K + k (B is tile-blocked: per N-tile, K row words).
  - After k=K-1 -> DRAIN.
- DRAIN: one cycle, covers the 1-cycle SRAM read latency. -> WRITE.
- WRITE: one cycle.
  - sram_c_we_o=1, sram_c_addr_o = mt*NT + nt.
  - row_valid_o[r] = (mt*RowPar + r < M).
  - col_valid_o[c] = (nt*ColPar + c < N).
  - Then nt++. If nt wraps past NT-1, nt=0 and mt++.
  - -> FETCH if tiles remain, else -> DONE.
- Tile order: nt inner, mt outer.
- DONE: done_o=1 for exactly one cycle, then -> IDLE.
- mac_valid_o and mac_init_save_o are the FETCH-cycle conditions (FETCH, and FETCH with k==0) delayed one cycle, to align with SRAM data.
- mac_acc_clr_o=1 in IDLE and DONE, 0 otherwise.
- busy_o=1 in FETCH, DRAIN and WRITE.
- Address arithmetic is unsigned and computed at AddrWidth, truncated modulo 2^AddrWidth. Counters are SizeAddrWidth wide.
- MT and NT calculations must not overflow for sizes up to 2^SizeAddrWidth-1, so intermediates are one bit wider.
- Reset mid-operation: all state returns to IDLE immediately. No write strobe is produced after reset asserts.

## Timing
- Reset values: all addresses 0, sram_c_we_o=0, mac_valid_o=0, mac_init_save_o=0, mac_acc_clr_o=1, masks 0, busy_o=0, done_o=0.
- start_i high at edge E0: first FETCH cycle is E0+1, with k=0 addresses presented.
- Per tile, with first FETCH cycle F:
  - addresses are valid in cycles F..F+K-1;
  - mac_valid_o is high in F+1..F+K;
  - mac_init_save_o is high in F+1;
  - DRAIN is in F+K;
  - WRITE (we=1) is in F+K+1, with accumulator output final at that edge.
- Next tile's FETCH starts at F+K+2. Each tile takes K+2 cycles.
- Job latency from start edge to done_o: 1 + MT*NT*(K+2) cycles.
- done_o is high in the cycle after the last WRITE.
- A start_i in the same cycle as done_o is ignored. The next accepted start is in IDLE, one cycle later.

## Test plan
- Single tile, M=4 K=3 N=16, start at E0 -> A/B addrs 0,1,2 in E0+1..E0+3. Valid high E0+2..E0+4, init_save at E0+2. we at E0+5 with C addr 0, row mask 4'hF, col mask 16'hFFFF. done at E0+6.
- Edge tiles, M=5 K=2 N=17 -> 4 writes at C addrs 0,1,2,3.
  - A addrs per tile: {0,1},{0,1},{2,3},{2,3}.
  - B addrs per tile: {0,1},{2,3},{0,1},{2,3}.
  - Masks per tile: rows F/F/1/1, cols FFFF/0001/FFFF/0001.
  - done 17 cycles after start.
- K=1, M=8 N=16 -> two tiles of 3 cycles each. init_save coincides with each valid pulse.
- Zero size (K=0) -> done_o pulses at start+1. we, valid and busy never assert.
- start_i held high throughout the job -> a single job runs. No restart is taken until IDLE after done.
- rst_ni low during the second FETCH of the M=5 K=2 N=17 job -> all outputs immediately take reset values. A subsequent start runs the full 4-tile sequence correctly.
